// File: rtl/forward_scoreboard.sv
// Forwarding / interlock unit placed between decode and EX.
// A DEPTH-entry shift scoreboard follows each in-flight register writer
// from EX towards WB. Each entry counts down until its result exists. Every
// decode source operand is either forwarded from the youngest matching
// producer, read from the register file, or causes a stall.
module forward_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_W     = 5,
    parameter int N_SRC      = 2,
    parameter int DEPTH      = 3,
    parameter int LAT_W      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_advance,
    input  logic                        i_flush,
    input  logic                        i_issue_valid,
    input  logic                        i_issue_uses_rw,
    input  logic [ADDR_W-1:0]           i_issue_rw_addr,
    input  logic [LAT_W-1:0]            i_issue_lat,
    input  logic [DEPTH-1:0]            i_result_valid,
    input  logic [DEPTH*DATA_WIDTH-1:0] i_result_data,
    input  logic [N_SRC-1:0]            i_src_uses,
    input  logic [N_SRC*ADDR_W-1:0]     i_src_addr,
    input  logic [N_SRC*DATA_WIDTH-1:0] i_src_rf_data,
    output logic [N_SRC*DATA_WIDTH-1:0] o_src_data,
    output logic                        o_stall,
    output logic [N_SRC-1:0]            o_hazard_src,
    output logic [31:0]                 o_stall_cycles
);

    // Issue latencies at or above DEPTH cannot be tracked by the countdown.
    localparam logic [LAT_W:0] DEPTH_L = DEPTH[LAT_W:0];

    logic [DEPTH-1:0]  valid_reg;
    logic [DEPTH-1:0]  valid_next;
    logic [ADDR_W-1:0] addr_reg  [DEPTH];
    logic [ADDR_W-1:0] addr_next [DEPTH];
    logic [LAT_W-1:0]  rem_reg   [DEPTH];
    logic [LAT_W-1:0]  rem_next  [DEPTH];
    logic [LAT_W-1:0]  rem_dec   [DEPTH];

    // Value each entry takes when the pipeline advances.
    logic [DEPTH-1:0]  in_valid;
    logic [ADDR_W-1:0] in_addr [DEPTH];
    logic [LAT_W-1:0]  in_rem  [DEPTH];

    logic        issue_accept;
    logic [31:0] stall_cnt_reg;

    // While stalled, the decoded instruction is held and a bubble enters EX.
    // Writes to $zero are never tracked.
    assign issue_accept = i_issue_valid & i_issue_uses_rw & ~o_stall
                        & (i_issue_rw_addr != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            // Countdown saturates at zero; it runs whether the entry shifts or holds.
            assign rem_dec[gi] = (rem_reg[gi] == '0) ? '0 : rem_reg[gi] - 1'b1;

            if (gi == 0) begin : g_head
                // A fresh issue starts its countdown at the requested latency.
                assign in_valid[gi] = issue_accept;
                assign in_addr[gi]  = i_issue_rw_addr;
                assign in_rem[gi]   = i_issue_lat;
            end else begin : g_tail
                assign in_valid[gi] = valid_reg[gi-1];
                assign in_addr[gi]  = addr_reg[gi-1];
                assign in_rem[gi]   = rem_dec[gi-1];
            end

            assign valid_next[gi] = i_advance ? in_valid[gi] : valid_reg[gi];
            assign addr_next[gi]  = i_advance ? in_addr[gi]  : addr_reg[gi];
            assign rem_next[gi]   = i_advance ? in_rem[gi]   : rem_dec[gi];
        end
    endgenerate

    // Scoreboard state; reset and flush squash every tracked writer.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
        for (int k = 0; k < DEPTH; k++) begin
            addr_reg[k] <= addr_next[k];
            rem_reg[k]  <= rem_next[k];
        end
    end

    generate
        for (gi = 0; gi < N_SRC; gi++) begin : g_src
            logic [ADDR_W-1:0]     src_addr;
            logic [DATA_WIDTH-1:0] rf_data;
            logic                  active;
            logic                  hit;
            logic                  hit_ready;
            logic [DATA_WIDTH-1:0] fwd_data;

            assign src_addr = i_src_addr[gi*ADDR_W +: ADDR_W];
            assign rf_data  = i_src_rf_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign active   = i_src_uses[gi] && (src_addr != '0);

            // Scan oldest to youngest so the youngest matching producer wins.
            always_comb begin
                hit       = 1'b0;
                hit_ready = 1'b0;
                fwd_data  = '0;
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (valid_reg[k] && (addr_reg[k] == src_addr)) begin
                        hit       = 1'b1;
                        hit_ready = (rem_reg[k] == '0) && i_result_valid[k];
                        fwd_data  = i_result_data[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end

            assign o_hazard_src[gi] = active & hit & ~hit_ready;
            assign o_src_data[gi*DATA_WIDTH +: DATA_WIDTH] =
                (active && hit && hit_ready) ? fwd_data : rf_data;
        end
    endgenerate

    assign o_stall = |o_hazard_src;

    // Saturating count of stalled cycles; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (o_stall && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign o_stall_cycles = stall_cnt_reg;

    // An accepted issue must carry a latency the scoreboard can count down.
    a_issue_lat : assert property (@(posedge clk) disable iff (rst)
        (i_advance && i_issue_valid && i_issue_uses_rw && !i_flush)
            |-> ({1'b0, i_issue_lat} < DEPTH_L));

endmodule
